// File: rtl/mod_exp_seq_if.sv
// mod_exp_seq <-> mon_prod command, completion and operand-memory bus.
// master: the sequencer side; slave: the Montgomery product engine side.
interface mod_exp_seq_if #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 256,
    parameter int LOG_BITLEN = 8
);
    logic                  mp_start;
    logic [1:0]            mp_op_code;
    logic [LOG_BITLEN:0]   mp_count;
    logic                  mp_stop;
    logic [ABITS-1:0]      mp_rd_addr;
    logic [DBITS-1:0]      mp_rd_data;
    logic                  mp_wr_en;
    logic [ABITS-1:0]      mp_wr_addr;
    logic [DBITS-1:0]      mp_wr_data;

    modport master (
        output mp_start,
        output mp_op_code,
        output mp_count,
        output mp_rd_data,
        input  mp_stop,
        input  mp_rd_addr,
        input  mp_wr_en,
        input  mp_wr_addr,
        input  mp_wr_data
    );

    modport slave (
        input  mp_start,
        input  mp_op_code,
        input  mp_count,
        input  mp_rd_data,
        output mp_stop,
        output mp_rd_addr,
        output mp_wr_en,
        output mp_wr_addr,
        output mp_wr_data
    );
endinterface

// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply sequencer driving mon_prod,
// plus the 4-word operand memory that mon_prod reads and writes back.
module mod_exp_seq #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 256,
    parameter int BITLEN     = 256,
    parameter int LOG_BITLEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [BITLEN-1:0]     exponent,
    input  logic [LOG_BITLEN:0]   exp_len,
    input  logic [LOG_BITLEN:0]   mp_iter,
    input  logic                  ld_en,
    input  logic [ABITS-1:0]      ld_addr,
    input  logic [DBITS-1:0]      ld_data,
    output logic                  busy,
    output logic                  done,
    output logic [DBITS-1:0]      result,
    mod_exp_seq_if.master         mp
);

    localparam int IW = $clog2(BITLEN);

    localparam logic [1:0] OPXX = 2'd0;
    localparam logic [1:0] OPXM = 2'd1;
    localparam logic [1:0] OPX1 = 2'd2;

    localparam logic [LOG_BITLEN:0] LEN_ONE = 1;
    localparam logic [IW-1:0]       IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ISSUE_FIN,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [BITLEN-1:0] exp_q;
    logic [IW-1:0]     idx;
    logic              stop_q;
    logic              fin;
    logic [DBITS-1:0]  mem [4];

    // Only addr[1:0] is decoded.
    logic unused;
    assign unused = ^{ld_addr[ABITS-1:2],
                      mp.mp_rd_addr[ABITS-1:2],
                      mp.mp_wr_addr[ABITS-1:2]};

    assign result = mem[0];

    // mon_prod write-back outranks a host load to the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ld_en && !busy) begin
                mem[ld_addr[1:0]] <= ld_data;
            end
            if (mp.mp_wr_en) begin
                mem[mp.mp_wr_addr[1:0]] <= mp.mp_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp.mp_rd_data <= '0;
        end else begin
            mp.mp_rd_data <= mem[mp.mp_rd_addr[1:0]];
        end
    end

    // Edge detect so a stop still high from the last op is not a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q <= 1'b0;
        end else begin
            stop_q <= mp.mp_stop;
        end
    end

    assign fin = mp.mp_stop & ~stop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            exp_q         <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mp.mp_start   <= 1'b0;
            mp.mp_op_code <= OPXX;
            mp.mp_count   <= '0;
        end else begin
            mp.mp_start <= 1'b0;
            done        <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        exp_q       <= exponent;
                        mp.mp_count <= mp_iter;
                        busy        <= 1'b1;
                        mp.mp_start <= 1'b1;
                        if (exp_len == '0) begin
                            mp.mp_op_code <= OPX1;
                            state         <= S_ISSUE_FIN;
                        end else begin
                            idx           <= IW'(exp_len - LEN_ONE);
                            mp.mp_op_code <= OPXX;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fin) begin
                        mp.mp_start <= 1'b1;
                        if (mp.mp_op_code == OPXX && exp_q[idx]) begin
                            mp.mp_op_code <= OPXM;
                            state         <= S_ISSUE;
                        end else if (idx == '0) begin
                            mp.mp_op_code <= OPX1;
                            state         <= S_ISSUE_FIN;
                        end else begin
                            idx           <= idx - IDX_ONE;
                            mp.mp_op_code <= OPXX;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE_FIN: begin
                    state <= S_WAIT_FIN;
                end
                S_WAIT_FIN: begin
                    if (fin) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Bench for mod_exp_seq: mon_prod stub, op-code scoreboard,
// memory latency/priority and reset-mid-run checks.
module tb_mod_exp_seq;

    localparam logic [1:0] XX = 2'd0;
    localparam logic [1:0] XM = 2'd1;
    localparam logic [1:0] X1 = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         go;
    logic [255:0] exponent;
    logic [8:0]   exp_len;
    logic [8:0]   mp_iter;
    logic         ld_en;
    logic [7:0]   ld_addr;
    logic [255:0] ld_data;
    logic         busy;
    logic         done;
    logic [255:0] result;

    mod_exp_seq_if #(.ABITS(8), .DBITS(256), .LOG_BITLEN(8)) mp_bus ();

    mod_exp_seq #(
        .ABITS(8), .DBITS(256), .BITLEN(256), .LOG_BITLEN(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .go(go),
        .exponent(exponent),
        .exp_len(exp_len),
        .mp_iter(mp_iter),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .busy(busy),
        .done(done),
        .result(result),
        .mp(mp_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mon_prod stub: stop drops on start, rises 5 cycles later.
    logic stub_stop = 1'b0;
    int   stub_cnt  = 0;
    logic stale     = 1'b0;

    always @(posedge clk) begin
        if (mp_bus.mp_start) begin
            stub_stop <= 1'b0;
            stub_cnt  <= 5;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_stop <= 1'b1;
        end
    end

    assign mp_bus.mp_stop = stub_stop | stale;

    int         errs  = 0;
    int         n_chk = 0;
    logic [1:0] exp_q [$];
    int         n_starts;
    int         n_done;
    int         last_cyc;
    bit         have_last;
    logic       prev_start;

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] want);
        n_chk++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called once per negedge while a run is in flight.
    task automatic mon();
        logic [1:0] op;
        if (mp_bus.mp_start) begin
            n_starts++;
            chk("start_width", 256'(prev_start), 256'(0));
            chk("op_queued", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                op = exp_q.pop_front();
                chk("op_code", 256'(mp_bus.mp_op_code), 256'(op));
            end
            if (have_last) begin
                chk("start_gap", 256'((cyc - last_cyc) >= 6), 256'(1));
            end
            last_cyc  = cyc;
            have_last = 1'b1;
        end
        prev_start = mp_bus.mp_start;
        if (done) begin
            n_done++;
            chk("busy_at_done", 256'(busy), 256'(0));
        end
    endtask

    task automatic push_ops(input logic [255:0] e, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            exp_q.push_back(XX);
            if (e[i]) exp_q.push_back(XM);
        end
        exp_q.push_back(X1);
    endtask

    task automatic ld(input int a, input logic [255:0] d);
        ld_en   = 1'b1;
        ld_addr = 8'(a);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic start_go(input logic [255:0] e, input int len);
        n_starts   = 0;
        n_done     = 0;
        have_last  = 1'b0;
        prev_start = 1'b0;
        exponent   = e;
        exp_len    = 9'(len);
        mp_iter    = 9'd17;
        go         = 1'b1;
        tick();
        go         = 1'b0;
        exponent   = '0;
        exp_len    = '0;
        mp_iter    = '0;
        mon();
    endtask

    task automatic run(input logic [255:0] e, input int len,
                       input bit poke, input bit stale_drop);
        int n_exp;
        int t;
        int since;
        push_ops(e, len);
        n_exp = exp_q.size();
        start_go(e, len);
        t     = 0;
        since = -1;
        while (n_done == 0 && t < 2000) begin
            if (poke && t == 4) begin
                ld_en    = 1'b1;
                ld_addr  = 8'd3;
                ld_data  = 256'h99;
                go       = 1'b1;
                exponent = e;
                exp_len  = 9'(len);
            end else begin
                ld_en = 1'b0;
                go    = 1'b0;
            end
            tick();
            mon();
            t++;
            if (since >= 0) since++;
            else if (n_starts > 0) since = 0;
            if (stale_drop && since == 3) stale = 1'b0;
        end
        ld_en = 1'b0;
        go    = 1'b0;
        chk("done_seen", 256'(n_done), 256'(1));
        repeat (20) begin
            tick();
            mon();
        end
        chk("n_starts", 256'(n_starts), 256'(n_exp));
        chk("n_done", 256'(n_done), 256'(1));
        chk("ops_left", 256'(exp_q.size()), 256'(0));
        chk("busy_after", 256'(busy), 256'(0));
        chk("mp_count", 256'(mp_bus.mp_count), 256'(17));
        exp_q.delete();
    endtask

    task automatic rd(input int a, output logic [255:0] d);
        mp_bus.mp_rd_addr = 8'(a);
        tick();
        d = mp_bus.mp_rd_data;
    endtask

    logic [255:0] v;
    int           t0;

    initial begin
        rst_n    = 1'b0;
        go       = 1'b0;
        exponent = '0;
        exp_len  = '0;
        mp_iter  = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        mp_bus.mp_rd_addr = '0;
        mp_bus.mp_wr_en   = 1'b0;
        mp_bus.mp_wr_addr = '0;
        mp_bus.mp_wr_data = '0;
        repeat (2) tick();

        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_start", 256'(mp_bus.mp_start), 256'(0));
        chk("rst_op", 256'(mp_bus.mp_op_code), 256'(0));
        chk("rst_result", result, 256'(0));
        chk("rst_rd_data", mp_bus.mp_rd_data, 256'(0));
        rst_n = 1'b1;
        tick();

        ld(2, 256'hABC);
        ld(0, 256'h1);
        ld(3, 256'h33);

        mp_bus.mp_rd_addr = 8'd2;
        tick();
        chk("rd_addr2", mp_bus.mp_rd_data, 256'hABC);
        mp_bus.mp_rd_addr = 8'd0;
        #1;
        chk("rd_latency", mp_bus.mp_rd_data, 256'hABC);
        tick();
        chk("rd_addr0", mp_bus.mp_rd_data, 256'h1);

        ld_en   = 1'b1;
        ld_addr = 8'd1;
        ld_data = 256'h11;
        mp_bus.mp_wr_en   = 1'b1;
        mp_bus.mp_wr_addr = 8'd1;
        mp_bus.mp_wr_data = 256'h22;
        tick();
        ld_en           = 1'b0;
        mp_bus.mp_wr_en = 1'b0;
        rd(1, v);
        chk("wr_priority", v, 256'h22);

        run(256'b1011, 4, 1'b1, 1'b0);
        rd(3, v);
        chk("ld_while_busy", v, 256'h33);
        chk("result_kept", result, 256'h1);

        mp_bus.mp_wr_en   = 1'b1;
        mp_bus.mp_wr_addr = 8'd0;
        mp_bus.mp_wr_data = 256'h55;
        tick();
        mp_bus.mp_wr_en   = 1'b0;
        chk("wb_result", result, 256'h55);

        run({256{1'b1}}, 0, 1'b0, 1'b0);

        push_ops(256'b1011, 4);
        start_go(256'b1011, 4);
        t0 = 0;
        while (n_starts < 3 && t0 < 500) begin
            tick();
            mon();
            t0++;
        end
        chk("reached_op3", 256'(n_starts), 256'(3));
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_start", 256'(mp_bus.mp_start), 256'(0));
        chk("mid_rst_result", result, 256'(0));
        exp_q.delete();
        stale = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        run({{252{1'b1}}, 4'b1011}, 4, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule
